// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int unsigned CLA_BLOCK_DEFAULT = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } cla_flags_t;

  function automatic bit params_ok(input int unsigned width, input int unsigned block);
    if (block == 0) return 1'b0;
    if (width < block) return 1'b0;
    return (width % block) == 0;
  endfunction

  // Guarded so illegal parameters still elaborate far enough to report the error.
  function automatic int unsigned nblk(input int unsigned width, input int unsigned block);
    if (block == 0 || width < block) return 1;
    return width / block;
  endfunction

endpackage

// File: rtl/cla_block.sv
// One BLOCK-wide carry-lookahead slice: two-level carries from group generate/propagate terms.
module cla_block
  import cla_pkg::*;
#(
  parameter int unsigned BLOCK = CLA_BLOCK_DEFAULT
) (
  input  logic [BLOCK-1:0] A,
  input  logic [BLOCK-1:0] B,
  input  logic             Cin,
  output logic [BLOCK-1:0] Sum,
  output logic             Cout,
  output logic             C_msb_in,
  output logic             G,
  output logic             P
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;
  logic             gen_acc;
  logic             prop_acc;

  always_comb begin
    g        = A & B;
    p        = A ^ B;
    c        = '0;
    c[0]     = Cin;
    gen_acc  = 1'b0;
    prop_acc = 1'b1;
    // Each carry is a flat sum of products walking down from bit i, not a ripple.
    for (int unsigned i = 0; i < BLOCK; i++) begin
      gen_acc  = 1'b0;
      prop_acc = 1'b1;
      for (int unsigned jj = 0; jj <= i; jj++) begin
        gen_acc  = gen_acc | (prop_acc & g[i-jj]);
        prop_acc = prop_acc & p[i-jj];
      end
      c[i+1] = gen_acc | (prop_acc & Cin);
    end
    G        = gen_acc;
    P        = prop_acc;
    Sum      = p ^ c[BLOCK-1:0];
    Cout     = c[BLOCK];
    C_msb_in = c[BLOCK-1];
  end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract: one lookahead slice per stage, carry and zero-so-far registered
// between stages, with valid/ready back-pressure that freezes the whole pipe.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = CLA_BLOCK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam int unsigned NB = nblk(WIDTH, BLOCK);

  if (!params_ok(WIDTH, BLOCK)) begin : g_bad_params
    $error("cla_pipe_addsub: WIDTH must be a nonzero multiple of BLOCK");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  always_comb begin
    b_eff   = Sub ? ~B : B;
    cin_eff = Sub ? ~Cin : Cin;
  end

  for (genvar k = 0; k < NB; k++) begin : g_stg
    localparam int unsigned SW = (k + 1) * BLOCK;

    logic [BLOCK-1:0] sa;
    logic [BLOCK-1:0] sb;
    logic [BLOCK-1:0] ssum;
    logic             sc;
    logic             sz;
    logic             sval;
    logic             scout;
    logic             smsb;
    logic             sg_unused;
    logic             sp_unused;
    logic             z_d;
    logic             valid_q;
    logic [SW-1:0]    sum_d;
    logic [SW-1:0]    sum_q;

    if (k == 0) begin : g_src
      always_comb begin
        sa    = A[BLOCK-1:0];
        sb    = b_eff[BLOCK-1:0];
        sc    = cin_eff;
        sz    = 1'b1;
        sval  = in_valid;
        sum_d = ssum;
      end
    end else begin : g_src
      always_comb begin
        sa    = g_stg[k-1].g_rem.a_q[BLOCK-1:0];
        sb    = g_stg[k-1].g_rem.b_q[BLOCK-1:0];
        sc    = g_stg[k-1].g_rem.c_q;
        sz    = g_stg[k-1].g_rem.z_q;
        sval  = g_stg[k-1].valid_q;
        sum_d = {ssum, g_stg[k-1].sum_q};
      end
    end

    cla_block #(.BLOCK(BLOCK)) u_blk (
      .A        (sa),
      .B        (sb),
      .Cin      (sc),
      .Sum      (ssum),
      .Cout     (scout),
      .C_msb_in (smsb),
      .G        (sg_unused),
      .P        (sp_unused)
    );

    always_comb begin
      z_d = sz & ~(|ssum);
    end

    // Data only loads with a real operand so a bubble never disturbs held results.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= sval;
        if (sval) sum_q <= sum_d;
      end
    end

    if (k < NB - 1) begin : g_rem
      localparam int unsigned RW = WIDTH - SW;

      logic [RW-1:0] a_d;
      logic [RW-1:0] b_d;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;
      logic          c_d;
      logic          c_q;
      logic          z_q;

      if (k == 0) begin : g_in
        always_comb begin
          a_d = A[WIDTH-1:BLOCK];
          b_d = b_eff[WIDTH-1:BLOCK];
        end
      end else begin : g_in
        always_comb begin
          a_d = g_stg[k-1].g_rem.a_q[RW+BLOCK-1:BLOCK];
          b_d = g_stg[k-1].g_rem.b_q[RW+BLOCK-1:BLOCK];
        end
      end

      always_comb begin
        c_d = scout;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
          z_q <= 1'b0;
        end else if (advance && sval) begin
          a_q <= a_d;
          b_q <= b_d;
          c_q <= c_d;
          z_q <= z_d;
        end
      end
    end else begin : g_fin
      cla_flags_t flags_d;
      cla_flags_t flags_q;

      always_comb begin
        flags_d   = '0;
        flags_d.n = ssum[BLOCK-1];
        flags_d.z = z_d;
        flags_d.c = scout;
        flags_d.v = smsb ^ scout;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          flags_q <= '0;
        end else if (advance && sval) begin
          flags_q <= flags_d;
        end
      end
    end
  end

  always_comb begin
    out_valid = g_stg[NB-1].valid_q;
    advance   = !out_valid || out_ready;
    in_ready  = advance;
    Sum       = g_stg[NB-1].sum_q;
    N         = g_stg[NB-1].g_fin.flags_q.n;
    Z         = g_stg[NB-1].g_fin.flags_q.z;
    Cout      = g_stg[NB-1].g_fin.flags_q.c;
    V         = g_stg[NB-1].g_fin.flags_q.v;
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and streaming checks for cla_pipe_addsub at WIDTH=16, BLOCK=4.
module tb_cla_pipe_addsub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        Sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Sum;
  logic        Cout;
  logic        V;
  logic        N;
  logic        Z;

  int n_cmp  = 0;
  int n_fail = 0;

  cla_pipe_addsub #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .V         (V),
    .N         (N),
    .Z         (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] dut_res;
  assign dut_res = {Sum, Cout, V, N, Z};

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [19:0] exp; // {sum, c, v, n, z}
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference built from wide integer arithmetic and sign rules.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [16:0] r;
    logic        v;
    logic        c;
    if (!sub) begin
      r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      v = (a[15] == b[15]) && (r[15] != a[15]);
      c = r[16];
    end else begin
      r = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      v = (a[15] != b[15]) && (r[15] != a[15]);
      c = ~r[16];
    end
    return {r[15:0], c, v, r[15], (r[15:0] == 16'd0)};
  endfunction

  logic [15:0] ra [8];
  logic [15:0] rb [8];
  logic        rc [8];
  logic        rs [8];
  logic [19:0] expq [$];
  logic [19:0] e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    int seen;

    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[2] = '{16'h0005, 16'h0005, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[4] = '{16'h0003, 16'h0004, 1'b0, 1'b1, {16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[5] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, {16'h1000, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{16'h1234, 16'h4321, 1'b1, 1'b0, {16'h5556, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{16'h0010, 16'h0001, 1'b1, 1'b1, {16'h000E, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[9] = '{16'h8000, 16'h8000, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b1, 1'b0, 1'b1}};

    for (int i = 0; i < 8; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rc[i] = 1'($urandom_range(0, 1));
      rs[i] = 1'($urandom_range(0, 1));
    end

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(dut_res), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed table: one operation at a time, exact 4-cycle latency.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; A = vecs[i].a; B = vecs[i].b; Cin = vecs[i].cin; Sub = vecs[i].sub;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        if (c < 4) check($sformatf("vec%0d_early_valid_c%0d", i, c), 32'(out_valid), 32'd0);
      end
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_result", i), 32'(dut_res), 32'(vecs[i].exp));
    end
    @(negedge clk);
    check("table_drained", 32'(out_valid), 32'd0);

    // Back-to-back stream with a 3-cycle output stall.
    sent = 0; got = 0;
    expq.delete();
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      if (cyc >= 5 && cyc <= 7) check($sformatf("stall_in_ready_c%0d", cyc), 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("stream_unexpected_output", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check($sformatf("stream_result%0d", got), 32'(dut_res), 32'(e));
        end
        got++;
      end
      if (sent < 8) begin
        in_valid = 1'b1; A = ra[sent]; B = rb[sent]; Cin = rc[sent]; Sub = rs[sent];
        #1;
        if (in_ready) begin
          expq.push_back(model(ra[sent], rb[sent], rc[sent], rs[sent]));
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", 32'(got), 32'd8);
    check("stream_queue_empty", 32'(expq.size()), 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("stream_no_duplicate", 32'(seen), 32'd0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = 16'h1111 * 16'(i + 1); B = 16'h0101; Cin = 1'b0; Sub = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_flushed", 32'(seen), 32'd0);

    in_valid = 1'b1; A = 16'h00FF; B = 16'h0F01; Cin = 1'b0; Sub = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (c < 4) check($sformatf("postrst_early_valid_c%0d", c), 32'(out_valid), 32'd0);
    end
    check("postrst_valid", 32'(out_valid), 32'd1);
    check("postrst_result", 32'(dut_res), 32'({16'h1000, 1'b0, 1'b0, 1'b0, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor that generalises the fixed 8-bit two-block CLA to any `WIDTH` that is a multiple of `BLOCK`. It adds one `BLOCK`-wide lookahead slice per pipeline stage and registers the carry between stages. It sits in the ALU datapath behind the operand mux. It adds a subtract mode, a valid/ready handshake with back-pressure, and N/Z/C/V status flags.

## Interface
- `WIDTH`, default 16: operand and result width. Must be a multiple of `BLOCK` and at least `BLOCK`.
- `BLOCK`, default 4: bits resolved per lookahead slice and per pipeline stage. `NBLK = WIDTH/BLOCK` stages.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: operand set present.
- `in_ready` out 1: stage 0 can accept this cycle.
- `A` in WIDTH: operand A, two's complement.
- `B` in WIDTH: operand B, two's complement.
- `Cin` in 1: carry-in when `Sub`=0; borrow-in when `Sub`=1.
- `Sub` in 1: 0 gives A+B+Cin; 1 gives A−B−Cin.
- `out_valid` out 1: result registers hold a valid result.
- `out_ready` in 1: consumer accepts the result.
- `Sum` out WIDTH: result.
- `Cout` out 1: raw carry out of the MSB. In subtract mode 1 means no borrow.
- `V` out 1: signed overflow.
- `N` out 1: `Sum[WIDTH-1]`.
- `Z` out 1: `Sum` equals 0.

## Operation
- **Operand transform**
  - Effective B = `Sub ? ~B : B`.
  - Effective carry-in = `Sub ? ~Cin : Cin`.
  - Result is `A + Beff + cin_eff` modulo 2^WIDTH.
- **Per-stage work (stage k, k = 0..NBLK−1)**
  - Computes result bits `[k*BLOCK +: BLOCK]` with a `BLOCK`-bit lookahead slice.
  - Carry-in is the carry registered by stage k−1. Stage 0 uses `cin_eff`.
- **Skew buffers**
  - Upper operand slices ride down the pipeline until their stage consumes them.
  - Finished lower result slices ride down until the output register.
- **Zero flag**
  - A running "all-zero-so-far" bit is ANDed per stage, so the last stage needs no WIDTH-wide compare.
- **Final stage**
  - `Cout` = carry out of the top slice.
  - `V` = carry into the MSB XOR carry out of the MSB.
  - `N` = MSB of `Sum`.
- **Handshake**
  - `advance = !out_valid || out_ready`, with `in_ready = advance`.
  - When `advance`=0 every stage, including valid bits, holds its value.
  - When `advance`=1 every stage shifts one place. A stage whose predecessor is invalid becomes invalid (a bubble). Stages never collapse bubbles out of order.
  - A transfer on either port occurs only when valid and ready are both 1 in the same cycle.
- **Reset**
  - Every valid bit clears, and `Sum`, `Cout`, `V`, `N`, `Z` clear to 0.
  - `in_ready` reads 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight operations. No partial result is ever emitted.
- **Parameter checks**
  - Illegal parameters (`WIDTH % BLOCK != 0`, `BLOCK` = 0) stop elaboration with `$error`.

## Timing
- Latency is `NBLK` cycles from an accepted input (edge E) to `out_valid`=1 after edge E+NBLK−1 (WIDTH=16, BLOCK=4 gives 4 cycles), provided no stall occurs.
- `NBLK`=1 degenerates to a single registered adder with latency 1.
- Throughput is one operation per cycle while `out_ready`=1.
- `in_ready` is combinational from `out_valid` and `out_ready`.
- No other combinational path runs input to output.
- Each stall cycle adds exactly one cycle of latency to every in-flight operation.
- If `out_ready` goes high in the same cycle as a new input, the output is consumed and the input accepted in that single cycle.
- The critical path is one `BLOCK`-bit lookahead slice plus the operand inversion mux in stage 0.

## Structure
- **Package `cla_pkg`**
  - `function nblk(WIDTH, BLOCK)`.
  - A flags struct `cla_flags_t {N, Z, C, V}`.
  - A localparam for the default `BLOCK` = 4.
- **Sub-module `cla_block`**
  - Combinational, parametrised by `BLOCK`.
  - Inputs `A`, `B`, `Cin`.
  - Outputs `Sum`, `Cout`, `C_msb_in` (carry into the slice's top bit, used for `V`), `G`, `P`.
  - Instantiated NBLK times in a generate loop, one per stage.

## Test plan
All scenarios use WIDTH=16, BLOCK=4.
- `A`=0x7FFF, `B`=0x0001, `Sub`=0, `Cin`=0 → exactly 4 cycles later: `Sum`=0x8000, `Cout`=0, `V`=1, `N`=1, `Z`=0.
- `A`=0xFFFF, `B`=0x0001, `Sub`=0, `Cin`=0 → `Sum`=0x0000, `Cout`=1, `Z`=1, `V`=0. Then 0x0005−0x0005 (`Sub`=1, `Cin`=0) → `Sum`=0x0000, `Cout`=1, `Z`=1.
- `A`=0x8000, `B`=0x0001, `Sub`=1, `Cin`=0 → `Sum`=0x7FFF, `V`=1, `Cout`=1, `N`=0. Then 0x0003−0x0004 → `Sum`=0xFFFF, `Cout`=0, `N`=1.
- Carry chain across all stages: `A`=0x0FFF, `B`=0x0000, `Sub`=0, `Cin`=1 → `Sum`=0x1000, `Cout`=0, `Z`=0.
- 8 back-to-back random operations with `out_ready` held low for 3 cycles mid-stream → `in_ready`=0 during those cycles, all 8 results emerge in order matching the reference model, with no loss or duplication.
- 3 operations in flight, then `rst` pulsed for 1 cycle → `out_valid`=0 from the next cycle, none of the 3 results ever appear, `in_ready`=1, and a new operation afterward returns after 4 cycles.
